// File: rtl/rr_mux_n.sv
// N-channel valid/ready arbiter-mux: round-robin or fixed-priority grant,
// registered output word tagged with the index of the channel that supplied it.

module rr_mux_n_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             i_valid,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_hi
);
  // A lane belongs to the upper search window when it sits at or after ptr.
  assign o_hi = i_valid & (i_ptr <= SEL_W'(IDX));
endmodule

module rr_mux_n #(
  parameter  int NUM_CH   = 4,
  parameter  int DATA_W   = 8,
  parameter  int ARB_MODE = 0,
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [SEL_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_sel;
  logic              r_out_valid;

  logic [NUM_CH-1:0] w_req_hi;
  logic              w_any;
  logic              w_load_en;
  logic [SEL_W-1:0]  w_gnt;
  logic [SEL_W-1:0]  w_gnt_hi;
  logic [SEL_W-1:0]  w_gnt_lo;
  logic [DATA_W-1:0] w_data;
  logic [SEL_W-1:0]  w_ptr_nxt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    rr_mux_n_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
      .i_valid (in_valid[i]),
      .i_ptr   (r_ptr),
      .o_hi    (w_req_hi[i])
    );
  end

  function automatic logic [SEL_W-1:0] f_lowest(input logic [NUM_CH-1:0] req);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req[i]) idx = SEL_W'(i);
    return idx;
  endfunction

  assign w_any     = |in_valid;
  assign w_load_en = !r_out_valid || out_ready;
  assign w_gnt_hi  = f_lowest(w_req_hi);
  assign w_gnt_lo  = f_lowest(in_valid);

  // Round-robin: first valid at/after ptr, else wrap to the lowest valid.
  assign w_gnt = (ARB_MODE == 0 && |w_req_hi) ? w_gnt_hi : w_gnt_lo;

  assign w_ptr_nxt = (w_gnt == SEL_W'(NUM_CH - 1)) ? '0 : w_gnt + SEL_W'(1);

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_gnt == SEL_W'(i)) w_data = in_data[i*DATA_W +: DATA_W];
  end

  // in_ready is held low during reset even though the output register is empty.
  assign in_ready = (w_load_en && w_any && !rst) ? (NUM_CH'(1) << w_gnt) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load_en) begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_out_data <= w_data;
        r_out_sel  <= w_gnt;
        if (ARB_MODE == 0) r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_n.sv
// Bench for rr_mux_n: three instances (RR/4, fixed/4, RR/3) driven in lockstep
// and compared each cycle against a queue-free cycle model of the arbitration rules.

module tb_rr_mux_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] d_r4, d_f4;
  logic [23:0] d_r3;
  logic [3:0]  v_r4, v_f4, ir_r4, ir_f4;
  logic [2:0]  v_r3, ir_r3;
  logic [7:0]  od_r4, od_f4, od_r3;
  logic [1:0]  os_r4, os_f4, os_r3;
  logic        ov_r4, ov_f4, ov_r3;
  logic        or_r4, or_f4, or_r3;

  rr_mux_n #(.NUM_CH(4), .DATA_W(8), .ARB_MODE(0)) u_r4 (
    .clk(clk), .rst(rst), .in_data(d_r4), .in_valid(v_r4), .in_ready(ir_r4),
    .out_data(od_r4), .out_sel(os_r4), .out_valid(ov_r4), .out_ready(or_r4));
  rr_mux_n #(.NUM_CH(4), .DATA_W(8), .ARB_MODE(1)) u_f4 (
    .clk(clk), .rst(rst), .in_data(d_f4), .in_valid(v_f4), .in_ready(ir_f4),
    .out_data(od_f4), .out_sel(os_f4), .out_valid(ov_f4), .out_ready(or_f4));
  rr_mux_n #(.NUM_CH(3), .DATA_W(8), .ARB_MODE(0)) u_r3 (
    .clk(clk), .rst(rst), .in_data(d_r3), .in_valid(v_r3), .in_ready(ir_r3),
    .out_data(od_r3), .out_sel(os_r3), .out_valid(ov_r3), .out_ready(or_r3));

  int         NCH  [3] = '{4, 4, 3};
  int         MODE [3] = '{0, 1, 0};
  logic [3:0] vld  [3];
  logic [7:0] dat  [3][4];
  logic       ordy [3];
  int         m_ptr[3];
  logic       m_ov [3];
  logic [7:0] m_od [3];
  int         m_os [3];
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic apply();
    v_r4 = vld[0]; v_f4 = vld[1]; v_r3 = vld[2][2:0];
    d_r4 = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
    d_f4 = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};
    d_r3 = {dat[2][2], dat[2][1], dat[2][0]};
    or_r4 = ordy[0]; or_f4 = ordy[1]; or_r3 = ordy[2];
  endtask

  // Walk channels starting at the pointer (or 0 for fixed priority), modulo N.
  function automatic int grant(input int k);
    int st;
    st = (MODE[k] != 0) ? 0 : m_ptr[k];
    for (int j = 0; j < NCH[k]; j++)
      if (vld[k][(st + j) % NCH[k]]) return (st + j) % NCH[k];
    return -1;
  endfunction

  function automatic logic [3:0] exp_ir(input int k);
    int g;
    g = grant(k);
    if (rst || g < 0 || (m_ov[k] && !ordy[k])) return 4'b0;
    return 4'(1 << g);
  endfunction

  function automatic logic [3:0] act_ir(input int k);
    case (k) 0: return ir_r4; 1: return ir_f4; default: return {1'b0, ir_r3}; endcase
  endfunction
  function automatic logic [7:0] act_od(input int k);
    case (k) 0: return od_r4; 1: return od_f4; default: return od_r3; endcase
  endfunction
  function automatic logic [1:0] act_os(input int k);
    case (k) 0: return os_r4; 1: return os_f4; default: return os_r3; endcase
  endfunction
  function automatic logic act_ov(input int k);
    case (k) 0: return ov_r4; 1: return ov_f4; default: return ov_r3; endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ptr[k] = 0; m_ov[k] = 1'b0; m_od[k] = 8'h00; m_os[k] = 0;
    end
  endtask

  task automatic check_out();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out_valid[%0d]", k), 32'(act_ov(k)), 32'(m_ov[k]));
      chk($sformatf("out_data[%0d]", k),  32'(act_od(k)), 32'(m_od[k]));
      chk($sformatf("out_sel[%0d]", k),   32'(act_os(k)), 32'(m_os[k]));
    end
  endtask

  // One cycle: drive at negedge, check in_ready, advance model on posedge, check outputs.
  task automatic step();
    int g;
    apply();
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("in_ready[%0d]", k), 32'(act_ir(k)), 32'(exp_ir(k)));
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      g = grant(k);
      if (!m_ov[k] || ordy[k]) begin
        m_ov[k] = (g >= 0);
        if (g >= 0) begin
          m_od[k] = dat[k][g];
          m_os[k] = g;
          if (MODE[k] == 0) m_ptr[k] = (g + 1) % NCH[k];
        end
      end
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic reset_pulse();
    apply();
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) chk($sformatf("rst_in_ready[%0d]", k), 32'(act_ir(k)), 32'(exp_ir(k)));
    check_out();
    #1 rst = 1'b0;
  endtask

  int seq4[6] = '{0, 1, 2, 3, 0, 1};
  int seq3[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    model_reset();
    for (int k = 0; k < 3; k++) begin
      vld[k] = (NCH[k] == 3) ? 4'b0111 : 4'b1111;
      ordy[k] = 1'b0;
      for (int i = 0; i < 4; i++) dat[k][i] = 8'hA0 + 8'(i);
    end
    apply();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("rst_in_ready[%0d]", k), 32'(act_ir(k)), 32'h0);
    check_out();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) ordy[k] = 1'b1;

    // All valid, drain every cycle: rotate through channels, one word per cycle.
    for (int s = 0; s < 6; s++) begin
      step();
      chk("rr4_sel", 32'(os_r4), 32'(seq4[s]));
      chk("rr4_data", 32'(od_r4), 32'(8'hA0 + 8'(seq4[s])));
      chk("rr3_sel", 32'(os_r3), 32'(seq3[s]));
      chk("fp4_sel", 32'(os_f4), 32'h0);
    end

    // Fixed priority: ch1 beats ch3 until ch1 drops.
    vld[1] = 4'b1010;
    repeat (3) begin step(); chk("fp_ch1", 32'(os_f4), 32'h1); end
    vld[1] = 4'b1000;
    step(); chk("fp_ch3", 32'(os_f4), 32'h3);

    // Backpressure: a held ch2 word stays put and blocks all inputs.
    vld[0] = 4'b0100; dat[0][2] = 8'h5C;
    step(); chk("bp_load_sel", 32'(os_r4), 32'h2);
    vld[0] = 4'b1111; ordy[0] = 1'b0;
    repeat (5) begin
      step();
      chk("bp_data", 32'(od_r4), 32'h5C);
      chk("bp_sel", 32'(os_r4), 32'h2);
      chk("bp_ready", 32'(ir_r4), 32'h0);
    end
    ordy[0] = 1'b1;
    step(); chk("bp_next", 32'(os_r4), 32'h3);

    // Idle gap after a ch3 transfer leaves the pointer wrapped at 0.
    vld[0] = 4'b1000;
    step(); chk("wrap_ch3", 32'(os_r4), 32'h3);
    vld[0] = 4'b0000;
    repeat (2) step();
    chk("idle_valid", 32'(ov_r4), 32'h0);
    vld[0] = 4'b1001;
    step(); chk("wrap_ch0", 32'(os_r4), 32'h0);

    // Randomized traffic with stalls, dropped valids and occasional mid-stream reset.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 3; k++) begin
        vld[k] = 4'($urandom_range(0, 15));
        if (NCH[k] == 3) vld[k][3] = 1'b0;
        ordy[k] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) dat[k][i] = 8'($urandom);
      end
      if ($urandom_range(0, 79) == 0) reset_pulse();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
